// File: rtl/dmem_pkg.sv
// Shared encodings and payload types for the data-memory access controller.
package dmem_pkg;

    localparam int unsigned ADDR_BITS_DEF = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WRITE  = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    typedef struct packed {
        logic        id;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lane_merge.sv
// Combinational lane logic: extracts a load value from a memory word and
// merges sub-word store data into it.
module dmem_lane_merge
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_c,
    output logic [31:0] o_merge_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte    = 8'(i_word >> {i_addr_lo, 3'b000});
        w_half    = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        o_load_c  = i_word;
        o_merge_c = i_wdata;
        case (size_e'(i_size))
            SZ_BYTE: begin
                o_load_c  = {{24{i_signed & w_byte[7]}}, w_byte};
                o_merge_c = i_word;
                o_merge_c[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load_c  = {{16{i_signed & w_half[15]}}, w_half};
                o_merge_c = i_word;
                if (i_addr_lo[1]) o_merge_c[31:16] = i_wdata[15:0];
                else              o_merge_c[15:0]  = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arb_ctrl.sv
// Two-master round-robin access controller for the word-wide data memory;
// sub-word stores are done as read-modify-write.
module dmem_arb_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic        m0_signed,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic        m1_signed,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      r_state;
    state_e      w_state_nxt;
    dmem_req_t   r_req;
    logic        r_rr;

    dmem_req_t   w_req;
    logic        w_gnt_any;
    logic        w_req_err;
    logic        w_subword_st;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    logic        w_mem_we_nxt;
    logic [31:0] w_mem_addr_nxt;
    logic [31:0] w_mem_wdata_nxt;
    logic        w_rsp_vld;
    logic        w_rsp_id;
    logic        w_rsp_err;
    logic [31:0] w_rsp_data;

    // Arbitration: a tie goes to the master r_rr favours.
    always_comb begin
        w_gnt_any = m0_req | m1_req;
        w_req.id  = (m0_req & m1_req) ? r_rr : m1_req;
        if (w_req.id) begin
            w_req.we    = m1_we;
            w_req.size  = m1_size;
            w_req.sgn   = m1_signed;
            w_req.addr  = m1_addr;
            w_req.wdata = m1_wdata;
        end else begin
            w_req.we    = m0_we;
            w_req.size  = m0_size;
            w_req.sgn   = m0_signed;
            w_req.addr  = m0_addr;
            w_req.wdata = m0_wdata;
        end
    end

    // Reserved size, misalignment or any address bit beyond the backed range.
    always_comb begin
        w_req_err = 1'b0;
        case (size_e'(w_req.size))
            SZ_BYTE: w_req_err = 1'b0;
            SZ_HALF: w_req_err = w_req.addr[0];
            SZ_WORD: w_req_err = |w_req.addr[1:0];
            default: w_req_err = 1'b1;
        endcase
        if ((w_req.addr >> ADDR_BITS) != 32'd0) w_req_err = 1'b1;
    end

    assign w_subword_st = r_req.we & (size_e'(r_req.size) != SZ_WORD);

    dmem_lane_merge u_lane (
        .i_word    (mem_rdata),
        .i_addr_lo (r_req.addr[1:0]),
        .i_size    (r_req.size),
        .i_signed  (r_req.sgn),
        .i_wdata   (r_req.wdata),
        .o_load_c  (w_load),
        .o_merge_c (w_merge)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_gnt_any) w_state_nxt = w_req_err ? ST_RESP : ST_ACCESS;
            ST_ACCESS: w_state_nxt = w_subword_st ? ST_WRITE : ST_RESP;
            ST_WRITE:  w_state_nxt = ST_RESP;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, so memory signals are valid
    // for the whole cycle of the state they belong to.
    always_comb begin
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        w_rsp_vld       = 1'b0;
        w_rsp_id        = r_req.id;
        w_rsp_err       = 1'b0;
        w_rsp_data      = '0;
        case (r_state)
            ST_IDLE: begin
                w_rsp_id = w_req.id;
                if (w_gnt_any && w_req_err) begin
                    w_rsp_vld = 1'b1;
                    w_rsp_err = 1'b1;
                end else if (w_gnt_any) begin
                    w_mem_addr_nxt = {w_req.addr[31:2], 2'b00};
                    if (w_req.we && size_e'(w_req.size) == SZ_WORD) begin
                        w_mem_we_nxt    = 1'b1;
                        w_mem_wdata_nxt = w_req.wdata;
                    end
                end
            end
            ST_ACCESS: begin
                if (w_subword_st) begin
                    w_mem_we_nxt    = 1'b1;
                    w_mem_addr_nxt  = {r_req.addr[31:2], 2'b00};
                    w_mem_wdata_nxt = w_merge;
                end else begin
                    w_rsp_vld  = 1'b1;
                    w_rsp_data = r_req.we ? 32'd0 : w_load;
                end
            end
            ST_WRITE: w_rsp_vld = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_ack    <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            mem_we    <= w_mem_we_nxt;
            mem_addr  <= w_mem_addr_nxt;
            mem_wdata <= w_mem_wdata_nxt;
            m0_ack    <= w_rsp_vld & ~w_rsp_id;
            m0_err    <= w_rsp_vld & ~w_rsp_id & w_rsp_err;
            m0_rdata  <= (w_rsp_vld & ~w_rsp_id) ? w_rsp_data : 32'd0;
            m1_ack    <= w_rsp_vld & w_rsp_id;
            m1_err    <= w_rsp_vld & w_rsp_id & w_rsp_err;
            m1_rdata  <= (w_rsp_vld & w_rsp_id) ? w_rsp_data : 32'd0;
        end
    end

    // Request context is captured on grant; the pointer flips after each response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req <= '0;
            r_rr  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_gnt_any) r_req <= w_req;
            if (r_state == ST_RESP)              r_rr  <= ~r_req.id;
        end
    end

endmodule
